// File: rtl/pl_exmul_if.sv
// Execute-stage handshake bundle for pl_exmul.
// master drives the ID/EX side; slave is the execute stage.
interface pl_exmul_if #(
  parameter int W = 8
);
  logic [3:0]   id_opcode;
  logic [W-1:0] id_op_a;
  logic [W-1:0] id_op_b;
  logic [0:6]   id_ctrl;
  logic         id_compare;
  logic         carry_in;
  logic         flush_ex;
  logic [W-1:0] operation_result;
  logic [0:6]   EX_reg;
  logic [0:4]   branch_conds_EX;
  logic         stall_out;

  modport master (
    output id_opcode, id_op_a, id_op_b, id_ctrl,
    output id_compare, carry_in, flush_ex,
    input  operation_result, EX_reg,
    input  branch_conds_EX, stall_out
  );

  modport slave (
    input  id_opcode, id_op_a, id_op_b, id_ctrl,
    input  id_compare, carry_in, flush_ex,
    output operation_result, EX_reg,
    output branch_conds_EX, stall_out
  );
endinterface

// File: rtl/pl_exmul.sv
// Execute stage: per-domain 8-bit ALU plus an 8-cycle
// shift-add multiplier that stalls the front end.
module pl_exmul #(
  parameter int NUM_DOMAINS  = 1,
  parameter int PROG_CTR_WID = 10
) (
  input logic      clk,
  input logic      reset,
  pl_exmul_if.slave bus
);
  localparam int W  = NUM_DOMAINS * 8;
  localparam int D1 = W - 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_ADC = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  localparam logic [31:0] PC_W = 32'(PROG_CTR_WID);
  logic unused_pc;
  assign unused_pc = ^PC_W;

  // returns {cout, result} for one 8-bit domain
  function automatic logic [8:0] alu8(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       ci
  );
    logic [8:0] r;
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    case (op)
      OP_ADD: r = {1'b0, a} + {1'b0, b};
      OP_ADC: r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      OP_SUB: r = {~d[8], d[7:0]};
      OP_CMP: r = {~d[8], a};
      OP_AND: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_XOR: r = {1'b0, a ^ b};
      OP_NOT: r = {1'b0, ~a};
      OP_SHL: r = {a[7], a[6:0], 1'b0};
      OP_SHR: r = {a[0], 1'b0, a[7:1]};
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

  function automatic logic [0:4] flags(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       c,
    input logic       cmp
  );
    return {a > b, a == b, a < b, c, cmp};
  endfunction

  logic [0:0]   state;
  logic [2:0]   cnt;
  logic [W-1:0] acc;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [0:6]   mul_ctrl;
  logic         mul_cmp;

  logic [W-1:0] alu_res;
  logic         alu_cout;
  logic [W-1:0] mul_next;
  logic [8:0]   dres [NUM_DOMAINS];

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      dres[d] = alu8(bus.id_opcode, bus.id_op_a[d*8 +: 8],
                     bus.id_op_b[d*8 +: 8], bus.carry_in);
      alu_res[d*8 +: 8] = dres[d][7:0];
    end
    alu_cout = dres[NUM_DOMAINS-1][8];
  end

  // one partial product per domain per cycle, bit cnt of B
  always_comb begin
    mul_next = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      mul_next[d*8 +: 8] = acc[d*8 +: 8] +
        (mul_b[d*8 + int'(cnt)] ? (mul_a[d*8 +: 8] << cnt) : 8'd0);
    end
  end

  assign bus.stall_out = (state == MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      acc                  <= '0;
      mul_a                <= '0;
      mul_b                <= '0;
      mul_ctrl             <= '0;
      mul_cmp              <= 1'b0;
      bus.operation_result <= '0;
      bus.EX_reg           <= '0;
      bus.branch_conds_EX  <= '0;
    end else begin
      bus.operation_result <= '0;
      bus.EX_reg           <= '0;
      bus.branch_conds_EX  <= '0;
      case (state)
        IDLE: begin
          if (bus.flush_ex) begin
            state <= IDLE;
          end else if (bus.id_opcode == OP_MUL) begin
            mul_a    <= bus.id_op_a;
            mul_b    <= bus.id_op_b;
            mul_ctrl <= bus.id_ctrl;
            mul_cmp  <= bus.id_compare;
            acc      <= '0;
            cnt      <= '0;
            state    <= MUL;
          end else begin
            bus.operation_result <= alu_res;
            bus.EX_reg           <= bus.id_ctrl;
            bus.branch_conds_EX  <= flags(
              bus.id_op_a[D1 +: 8], bus.id_op_b[D1 +: 8],
              alu_cout, bus.id_compare);
          end
        end
        MUL: begin
          if (bus.flush_ex) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
          end else if (cnt == 3'd7) begin
            bus.operation_result <= mul_next;
            bus.EX_reg           <= mul_ctrl;
            bus.branch_conds_EX  <= flags(
              mul_a[D1 +: 8], mul_b[D1 +: 8], 1'b0, mul_cmp);
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
          end else begin
            acc <= mul_next;
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pl_exmul.sv
// Directed scoreboard bench for pl_exmul: ALU ops, multiply
// latency, flush/reset aborts and a two-domain add.
module tb_pl_exmul;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  pl_exmul_if #(.W(8))  b1 ();
  pl_exmul_if #(.W(16)) b2 ();

  pl_exmul #(.NUM_DOMAINS(1), .PROG_CTR_WID(10)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  pl_exmul #(.NUM_DOMAINS(2), .PROG_CTR_WID(10)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic [6:0] ctrl;
    logic [4:0] fl;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       cmp;
    logic [6:0] ctrl;
    logic [7:0] res;
    logic [4:0] fl;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [6:0] ctrl,
                       input logic cmp, input logic ci,
                       input logic fl);
    b1.id_opcode  = op;
    b1.id_op_a    = a;
    b1.id_op_b    = b;
    b1.id_ctrl    = ctrl;
    b1.id_compare = cmp;
    b1.carry_in   = ci;
    b1.flush_ex   = fl;
  endtask

  task automatic idle();
    drive(4'h0, 8'h00, 8'h00, 7'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [7:0] res,
                      input logic [6:0] ctrl, input logic [4:0] fl);
    exp_t e;
    e.tag = tag; e.res = res; e.ctrl = ctrl; e.fl = fl;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty got=0 want=1");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_res"}, 32'(b1.operation_result), 32'(e.res));
      chk({e.tag, "_ctrl"}, 32'(b1.EX_reg), 32'(e.ctrl));
      chk({e.tag, "_flags"}, 32'(b1.branch_conds_EX), 32'(e.fl));
      chk({e.tag, "_stall"}, 32'(b1.stall_out), 32'd0);
    end
  endtask

  task automatic bubble(input string tag, input logic stall);
    chk({tag, "_res"}, 32'(b1.operation_result), 32'd0);
    chk({tag, "_ctrl"}, 32'(b1.EX_reg), 32'd0);
    chk({tag, "_flags"}, 32'(b1.branch_conds_EX), 32'd0);
    chk({tag, "_stall"}, 32'(b1.stall_out), 32'(stall));
  endtask

  task automatic mul_wait(input string tag);
    for (int i = 0; i < 8; i++) begin
      bubble(tag, 1'b1);
      drive(4'h1, 8'h55, 8'h66, 7'b1111111, 1'b1, 1'b1, 1'b0);
      tick();
    end
    idle();
  endtask

  initial begin
    vt[0]  = '{4'h2, 8'h10, 8'h20, 1'b1, 1'b0, 7'b0100000, 8'h31, 5'b00100};
    vt[1]  = '{4'h4, 8'hF0, 8'h3C, 1'b0, 1'b0, 7'b1010101, 8'h30, 5'b10000};
    vt[2]  = '{4'h5, 8'hF0, 8'h0F, 1'b0, 1'b0, 7'b0000111, 8'hFF, 5'b10000};
    vt[3]  = '{4'h6, 8'hFF, 8'h0F, 1'b0, 1'b0, 7'b0001000, 8'hF0, 5'b10000};
    vt[4]  = '{4'h7, 8'h0F, 8'h00, 1'b0, 1'b0, 7'b0100000, 8'hF0, 5'b10000};
    vt[5]  = '{4'h8, 8'h81, 8'h00, 1'b0, 1'b0, 7'b0110000, 8'h02, 5'b10010};
    vt[6]  = '{4'h9, 8'h81, 8'h00, 1'b0, 1'b0, 7'b0100000, 8'h40, 5'b10010};
    vt[7]  = '{4'hB, 8'h03, 8'h07, 1'b0, 1'b1, 7'b0000000, 8'h03, 5'b00101};
    vt[8]  = '{4'h0, 8'h00, 8'h5A, 1'b0, 1'b0, 7'b1000000, 8'h5A, 5'b00100};
    vt[9]  = '{4'hF, 8'h11, 8'h22, 1'b0, 1'b0, 7'b0100000, 8'h22, 5'b00100};
    vt[10] = '{4'h1, 8'hFF, 8'h01, 1'b1, 1'b0, 7'b0100000, 8'h00, 5'b10010};
    vt[11] = '{4'h3, 8'h03, 8'h05, 1'b0, 1'b0, 7'b0100000, 8'hFE, 5'b00100};

    reset = 1'b1;
    idle();
    b2.id_opcode = 4'h0; b2.id_op_a = '0; b2.id_op_b = '0;
    b2.id_ctrl = '0; b2.id_compare = 1'b0;
    b2.carry_in = 1'b0; b2.flush_ex = 1'b0;
    tick();
    tick();
    bubble("reset", 1'b0);
    chk("reset_d2", 32'(b2.operation_result), 32'd0);
    reset = 1'b0;

    drive(4'h1, 8'hF0, 8'h20, 7'b0100000, 1'b0, 1'b0, 1'b0);
    push("add", 8'h10, 7'b0100000, 5'b10010);
    b2.id_opcode = 4'h1;
    b2.id_op_a = 16'h01FF;
    b2.id_op_b = 16'h0101;
    b2.id_ctrl = 7'b0100000;
    tick();
    pop_check();
    chk("d2_res", 32'(b2.operation_result), 32'h0200);
    chk("d2_flags", 32'(b2.branch_conds_EX), 32'b01000);
    chk("d2_ctrl", 32'(b2.EX_reg), 32'b0100000);
    b2.id_opcode = 4'h0;

    drive(4'h3, 8'h05, 8'h05, 7'b0000000, 1'b1, 1'b0, 1'b0);
    push("sub", 8'h00, 7'b0000000, 5'b01011);
    tick();
    pop_check();

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].ctrl,
            vt[i].cmp, vt[i].ci, 1'b0);
      push($sformatf("op%0d", i), vt[i].res, vt[i].ctrl, vt[i].fl);
      tick();
      pop_check();
    end

    drive(4'h1, 8'hF0, 8'h20, 7'b0100000, 1'b0, 1'b0, 1'b1);
    tick();
    bubble("flush_idle", 1'b0);
    drive(4'hA, 8'h0D, 8'h0B, 7'b0100000, 1'b0, 1'b0, 1'b1);
    tick();
    bubble("flush_idle_mul", 1'b0);

    drive(4'hA, 8'h0D, 8'h0B, 7'b0100000, 1'b0, 1'b0, 1'b0);
    push("mul", 8'h8F, 7'b0100000, 5'b10000);
    tick();
    mul_wait("mul_wait");
    pop_check();

    drive(4'hA, 8'h07, 8'h03, 7'b0001000, 1'b1, 1'b0, 1'b0);
    push("mul2", 8'h15, 7'b0001000, 5'b10001);
    tick();
    mul_wait("mul2_wait");
    pop_check();

    drive(4'hA, 8'h10, 8'h10, 7'b0100000, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    bubble("mulf_c0", 1'b1);
    tick();
    tick();
    tick();
    b1.flush_ex = 1'b1;
    tick();
    bubble("mul_flush3", 1'b0);
    drive(4'h1, 8'h01, 8'h02, 7'b0100000, 1'b0, 1'b0, 1'b0);
    push("add_after_flush", 8'h03, 7'b0100000, 5'b00100);
    tick();
    pop_check();

    drive(4'hA, 8'h02, 8'h03, 7'b0100000, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 7; i++) tick();
    bubble("mulf_c7", 1'b1);
    b1.flush_ex = 1'b1;
    tick();
    bubble("mul_flush7", 1'b0);
    idle();

    drive(4'hA, 8'h0D, 8'h0B, 7'b0100000, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    reset = 1'b1;
    b1.flush_ex = 1'b1;
    tick();
    bubble("rst_mul", 1'b0);
    reset = 1'b0;
    drive(4'h1, 8'h0D, 8'h0B, 7'b0100000, 1'b0, 1'b0, 1'b0);
    push("add_after_rst", 8'h18, 7'b0100000, 5'b10000);
    tick();
    pop_check();
    idle();

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
